// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results to writeback and runs loads and stores
// against an external 16-bit asynchronous SRAM, stalling upstream while an access is in flight.
module mem_stage #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 2,
  parameter logic [3:0]  NOP_REG = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       memi_instr,
  input  logic [15:0]       memi_pc,
  input  logic [15:0]       memi_result,
  input  logic [3:0]        memi_wreg_addr,
  input  logic [15:0]       memi_write_to_mem_data,
  input  logic [1:0]        memi_rwe,
  output logic [15:0]       memo_instr,
  output logic [15:0]       memo_pc,
  output logic [15:0]       memo_wdata,
  output logic [3:0]        memo_wreg_addr,
  output logic              memo_wreg_en,
  output logic              memo_stall,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [15:0]       ram_data,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  typedef enum logic [1:0] {StIdle, StRd, StWrPulse, StWrHold} state_e;

  localparam logic [7:0] RdLast = 8'(RD_WAIT - 1);
  localparam logic [7:0] WrLast = 8'(WR_WAIT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [15:0] wr_data_q;
  logic        is_load;
  logic        is_store;
  logic        wreg_valid;

  assign is_load    = (memi_rwe == 2'b01);
  assign is_store   = (memi_rwe == 2'b10);
  assign wreg_valid = (memi_wreg_addr != NOP_REG);

  // Data is held through WR_HOLD so it stays valid past the we_n rising edge.
  assign ram_data = (state_q == StWrPulse || state_q == StWrHold) ? wr_data_q : 16'hzzzz;

  always_comb begin
    memo_stall = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle:    memo_stall = is_load | is_store;
        StRd:      memo_stall = (cnt_q != RdLast);
        StWrPulse: memo_stall = 1'b1;
        StWrHold:  memo_stall = 1'b0;
        default:   memo_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      wr_data_q      <= '0;
      memo_instr     <= '0;
      memo_pc        <= '0;
      memo_wdata     <= '0;
      memo_wreg_addr <= '0;
      memo_wreg_en   <= 1'b0;
      ram_addr       <= '0;
      ram_ce_n       <= 1'b1;
      ram_oe_n       <= 1'b1;
      ram_we_n       <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_load) begin
            ram_addr     <= ADDR_W'(memi_result);
            ram_ce_n     <= 1'b0;
            ram_oe_n     <= 1'b0;
            cnt_q        <= '0;
            memo_wreg_en <= 1'b0;
            state_q      <= StRd;
          end else if (is_store) begin
            ram_addr     <= ADDR_W'(memi_result);
            wr_data_q    <= memi_write_to_mem_data;
            ram_ce_n     <= 1'b0;
            ram_we_n     <= 1'b0;
            cnt_q        <= '0;
            memo_wreg_en <= 1'b0;
            state_q      <= StWrPulse;
          end else begin
            memo_instr     <= memi_instr;
            memo_pc        <= memi_pc;
            memo_wdata     <= memi_result;
            memo_wreg_addr <= memi_wreg_addr;
            memo_wreg_en   <= wreg_valid;
          end
        end
        StRd: begin
          if (cnt_q == RdLast) begin
            memo_instr     <= memi_instr;
            memo_pc        <= memi_pc;
            memo_wdata     <= ram_data;
            memo_wreg_addr <= memi_wreg_addr;
            memo_wreg_en   <= wreg_valid;
            ram_ce_n       <= 1'b1;
            ram_oe_n       <= 1'b1;
            state_q        <= StIdle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StWrPulse: begin
          if (cnt_q == WrLast) begin
            ram_we_n <= 1'b1;
            state_q  <= StWrHold;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StWrHold: begin
          ram_ce_n       <= 1'b1;
          memo_instr     <= memi_instr;
          memo_pc        <= memi_pc;
          memo_wdata     <= memi_result;
          memo_wreg_addr <= memi_wreg_addr;
          memo_wreg_en   <= 1'b0;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
